// File: rtl/kpn_pkg.sv
// Shared definitions for the KPN process nodes.
//   - default product and accumulator widths
//   - accumulator FSM state encoding
//   - clog2 helper used to size pointers, counters and indices
package kpn_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ACC_W_DEF  = 40;

    // Accumulator FSM state encoding
    typedef logic [0:0] acc_state_t;
    localparam acc_state_t ACCUM = 1'b0;
    localparam acc_state_t EMIT  = 1'b1;

    // Ceiling log2.  Returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/kpn_fifo.sv
// Blocking-read channel FIFO between two KPN nodes.
// Ports:
//   clk, reset   rising-edge clock, async active-high reset (empties the FIFO)
//   push, din    write request / data; ignored while full
//   pop, dout    read request / head-of-queue data; ignored while empty
//   full, empty  occupancy flags decoded from the count register
module kpn_fifo
    import kpn_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push, do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A push while full is dropped even if a pop frees a slot this cycle,
    // so the ready seen upstream is never optimistic.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dot_product_accumulator_module.sv
// KPN node downstream of the multiplier: sums each group of BLOCK_LEN
// products and emits one ACC_W-wide result per group.
// Ports:
//   clk, reset                        clock, async active-high reset
//   entry_1 / _valid / _ready         product input channel (buffered by FIFO)
//   output_1 / _valid / _ready        dot-product result channel
// The accumulator sums modulo 2^ACC_W; overflow wraps silently.
module dot_product_accumulator_module
    import kpn_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int ACC_W      = ACC_W_DEF,
    parameter int BLOCK_LEN  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] entry_1,
    input  logic              entry_1_valid,
    output logic              entry_1_ready,
    output logic [ACC_W-1:0]  output_1,
    output logic              output_1_valid,
    input  logic              output_1_ready
);

    // One extra value so BLOCK_LEN = 1 still yields a 1-bit index.
    localparam int IDX_W = clog2(BLOCK_LEN + 1);

    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full, fifo_empty, fifo_pop;

    acc_state_t        state;
    logic [IDX_W-1:0]  idx;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  word_ext, sum;
    logic              last;

    kpn_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (entry_1_valid),
        .pop   (fifo_pop),
        .din   (entry_1),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign entry_1_ready = !fifo_full;

    // Pops happen only while accumulating; EMIT lets the FIFO fill up.
    assign fifo_pop = (state == ACCUM) && !fifo_empty;
    assign word_ext = ACC_W'(fifo_dout);
    // The first word of a group overwrites the stale sum.
    assign sum      = (idx == '0) ? word_ext : acc + word_ext;
    assign last     = (idx == IDX_W'(BLOCK_LEN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ACCUM;
            idx            <= '0;
            acc            <= '0;
            output_1       <= '0;
            output_1_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (fifo_pop) begin
                        acc <= sum;
                        if (last) begin
                            output_1       <= sum;
                            output_1_valid <= 1'b1;
                            idx            <= '0;
                            state          <= EMIT;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    // output_1 keeps its value after the handshake.
                    if (output_1_ready) begin
                        output_1_valid <= 1'b0;
                        state          <= ACCUM;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_accumulator_module.sv
module tb_dot_product_accumulator_module;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] entry;
    logic        in_valid;
    logic        out_ready;

    // Five instances with different configurations share the input stimulus;
    // each test looks only at the instance it targets.
    // sel: 0 BL=1, 1 BL=2, 2 BL=3, 3 BL=4 (ACC_W=40), 4 BL=2 ACC_W=32
    logic [39:0] o0, o1, o2, o3;
    logic [31:0] o4;
    logic        v0, v1, v2, v3, v4;
    logic        r0, r1, r2, r3, r4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dot_product_accumulator_module #(.DATA_W(32), .ACC_W(40), .BLOCK_LEN(1), .FIFO_DEPTH(4)) d0 (
        .clk(clk), .reset(reset), .entry_1(entry), .entry_1_valid(in_valid), .entry_1_ready(r0),
        .output_1(o0), .output_1_valid(v0), .output_1_ready(out_ready));
    dot_product_accumulator_module #(.DATA_W(32), .ACC_W(40), .BLOCK_LEN(2), .FIFO_DEPTH(4)) d1 (
        .clk(clk), .reset(reset), .entry_1(entry), .entry_1_valid(in_valid), .entry_1_ready(r1),
        .output_1(o1), .output_1_valid(v1), .output_1_ready(out_ready));
    dot_product_accumulator_module #(.DATA_W(32), .ACC_W(40), .BLOCK_LEN(3), .FIFO_DEPTH(4)) d2 (
        .clk(clk), .reset(reset), .entry_1(entry), .entry_1_valid(in_valid), .entry_1_ready(r2),
        .output_1(o2), .output_1_valid(v2), .output_1_ready(out_ready));
    dot_product_accumulator_module #(.DATA_W(32), .ACC_W(40), .BLOCK_LEN(4), .FIFO_DEPTH(4)) d3 (
        .clk(clk), .reset(reset), .entry_1(entry), .entry_1_valid(in_valid), .entry_1_ready(r3),
        .output_1(o3), .output_1_valid(v3), .output_1_ready(out_ready));
    dot_product_accumulator_module #(.DATA_W(32), .ACC_W(32), .BLOCK_LEN(2), .FIFO_DEPTH(4)) d4 (
        .clk(clk), .reset(reset), .entry_1(entry), .entry_1_valid(in_valid), .entry_1_ready(r4),
        .output_1(o4), .output_1_valid(v4), .output_1_ready(out_ready));

    function automatic logic [39:0] out_of(input int s);
        case (s)
            0: return o0;
            1: return o1;
            2: return o2;
            3: return o3;
            default: return {8'h00, o4};
        endcase
    endfunction

    function automatic logic vld_of(input int s);
        case (s)
            0: return v0;
            1: return v1;
            2: return v2;
            3: return v3;
            default: return v4;
        endcase
    endfunction

    function automatic logic rdy_of(input int s);
        case (s)
            0: return r0;
            1: return r1;
            2: return r2;
            3: return r3;
            default: return r4;
        endcase
    endfunction

    task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold valid until the selected instance accepts the word.
    task automatic push_word(input int s, input logic [31:0] w);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        entry    = w;
        for (int i = 0; i < 50 && !done; i++) begin
            if (rdy_of(s)) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!done) check("push_timeout", 40'd0, 40'd1);
    endtask

    task automatic wait_valid(input int s, input int max_cyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            if (vld_of(s)) seen = 1'b1;
            else tick();
        end
        if (!seen) check("valid_timeout", 40'd0, 40'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #12;
        reset = 1'b0;
        tick();
    endtask

    typedef struct {
        logic [31:0] a, b, c;
        logic [39:0] exp;
    } vec_t;

    vec_t tbl [4];

    initial begin
        logic [31:0] words [7];
        logic [39:0] res [$];
        logic [39:0] exp_q [$];
        logic [39:0] acc_m, hv;
        int          ptr, cnt_m;
        bit          hold;

        tbl[0] = '{a: 32'd400,        b: 32'd25,         c: 32'd90,         exp: 40'd515};
        tbl[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  c: 32'hFFFF_FFFF,  exp: 40'h2_FFFF_FFFD};
        tbl[2] = '{a: 32'd0,          b: 32'd0,          c: 32'd0,          exp: 40'd0};
        tbl[3] = '{a: 32'd1,          b: 32'd2,          c: 32'd3,          exp: 40'd6};

        reset     = 1'b1;
        in_valid  = 1'b0;
        entry     = '0;
        out_ready = 1'b1;
        #3;
        check("reset_out",   out_of(2), 40'd0);
        check("reset_valid", {39'd0, vld_of(2)}, 40'd0);
        check("reset_ready", {39'd0, rdy_of(2)}, 40'd1);
        #9;
        reset = 1'b0;
        tick();

        // Table: groups of three on BL=3, ready held high.
        foreach (tbl[i]) begin
            push_word(2, tbl[i].a);
            push_word(2, tbl[i].b);
            push_word(2, tbl[i].c);
            wait_valid(2, 10);
            check($sformatf("sum3_%0d", i), out_of(2), tbl[i].exp);
            tick();
            check($sformatf("valid_1cyc_%0d", i), {39'd0, vld_of(2)}, 40'd0);
            check($sformatf("out_retained_%0d", i), out_of(2), tbl[i].exp);
        end
        tick(); tick();
        check("no_extra_result", {39'd0, vld_of(2)}, 40'd0);

        // BL=1 latency: pushed at edge k, valid after edge k+1.
        do_reset();
        push_word(0, 32'd7);
        check("bl1_not_yet", {39'd0, vld_of(0)}, 40'd0);
        tick();
        check("bl1_valid", {39'd0, vld_of(0)}, 40'd1);
        check("bl1_out", out_of(0), 40'd7);

        // Backpressure on BL=2.
        do_reset();
        for (int i = 0; i < 7; i++) words[i] = 32'(i + 1);
        out_ready = 1'b0;
        ptr = 0;
        hold = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            entry    = words[ptr];
            if (rdy_of(1)) ptr++;
            tick();
            if (hold) check("bp_stable", out_of(1), 40'd3);
            hold = vld_of(1);
        end
        check("bp_out", out_of(1), 40'd3);
        check("bp_valid", {39'd0, vld_of(1)}, 40'd1);
        check("bp_ready_low", {39'd0, rdy_of(1)}, 40'd0);
        check("bp_accepted", 40'(ptr), 40'd6);
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            in_valid = (ptr < 7);
            entry    = words[ptr < 7 ? ptr : 6];
            if (in_valid && rdy_of(1)) ptr++;
            if (vld_of(1)) res.push_back(out_of(1));
            tick();
        end
        in_valid = 1'b0;
        check("bp_seven_accepted", 40'(ptr), 40'd7);
        check("bp_n_results", 40'(res.size()), 40'd3);
        if (res.size() == 3) begin
            check("bp_res0", res[0], 40'd3);
            check("bp_res1", res[1], 40'd7);
            check("bp_res2", res[2], 40'd11);
        end

        // 32-bit accumulator wrap.
        do_reset();
        push_word(4, 32'hFFFF_FFFF);
        push_word(4, 32'd2);
        wait_valid(4, 10);
        check("wrap32", out_of(4), 40'd1);

        // Async reset with a result pending and two words buffered.
        do_reset();
        out_ready = 1'b0;
        push_word(3, 32'd10);
        push_word(3, 32'd20);
        push_word(3, 32'd30);
        push_word(3, 32'd40);
        push_word(3, 32'd5);
        push_word(3, 32'd6);
        tick();
        check("pre_rst_valid", {39'd0, vld_of(3)}, 40'd1);
        check("pre_rst_out", out_of(3), 40'd100);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_out", out_of(3), 40'd0);
        check("mid_rst_valid", {39'd0, vld_of(3)}, 40'd0);
        check("mid_rst_ready", {39'd0, rdy_of(3)}, 40'd1);
        #1;
        reset = 1'b0;
        tick();
        out_ready = 1'b1;
        push_word(3, 32'd1);
        push_word(3, 32'd2);
        push_word(3, 32'd3);
        push_word(3, 32'd4);
        wait_valid(3, 10);
        check("post_rst_sum", out_of(3), 40'd10);

        // Random stall soak on BL=3 against a running-sum model.
        do_reset();
        acc_m = '0;
        cnt_m = 0;
        for (int c = 0; c < 2020; c++) begin
            in_valid  = (c < 2000) ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready = (c < 2000) ? 1'($urandom_range(0, 1)) : 1'b1;
            entry     = $urandom;
            if (in_valid && rdy_of(2)) begin
                acc_m = acc_m + 40'(entry);
                cnt_m++;
                if (cnt_m == 3) begin
                    exp_q.push_back(acc_m);
                    acc_m = '0;
                    cnt_m = 0;
                end
            end
            if (vld_of(2) && out_ready) begin
                if (exp_q.size() == 0) check("soak_extra_result", out_of(2), 40'd0);
                else check("soak_sum", out_of(2), exp_q.pop_front());
            end
            hold = vld_of(2) && !out_ready;
            hv   = out_of(2);
            tick();
            if (hold) begin
                check("soak_hold_valid", {39'd0, vld_of(2)}, 40'd1);
                check("soak_hold_out", out_of(2), hv);
            end
        end
        in_valid = 1'b0;
        check("soak_all_drained", 40'(exp_q.size()), 40'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_product_accumulator_module.md
Name: dot_product_accumulator_module

Overview:
- KPN process node directly downstream of multiplier_module.
- Consumes the 32-bit product stream through a small blocking-read FIFO channel.
- Sums each group of BLOCK_LEN consecutive products and emits one wide dot-product result per group over a valid/ready channel.
- Gives the multiplier→accumulator pair Kahn semantics: the producer stalls when the channel is full, and the consumer stalls when it is empty.

Parameters:
- DATA_W, 32: width of incoming products (entry_1).
- ACC_W, 40: accumulator and result width; must be ≥ DATA_W.
- BLOCK_LEN, 4: products per result; must be ≥ 1.
- FIFO_DEPTH, 4: input channel depth; power of two, ≥ 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- entry_1  input  DATA_W  product from the upstream multiplier.
- entry_1_valid  input  1  entry_1 holds a product.
- entry_1_ready  output  1  channel can accept; a push occurs when valid & ready at the clk edge.
- output_1  output  ACC_W  accumulated dot product.
- output_1_valid  output  1  output_1 holds a result.
- output_1_ready  input  1  downstream accepts; a transfer occurs when valid & ready at the clk edge.

Behaviour:
- Reset (async assert, takes effect immediately): FIFO emptied, accumulator = 0, index counter = 0, FSM = ACCUM, output_1 = 0, output_1_valid = 0.
- entry_1_ready = !full, decoded combinationally from the FIFO occupancy count. It is 1 during and after reset.
- FIFO push/pop rules:
  - Push when entry_1_valid & entry_1_ready.
  - When full, no push, even if a pop happens in the same cycle.
  - Simultaneous push and pop when neither full nor empty: occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM state ACCUM:
  - If FIFO not empty: pop one word.
  - If idx == 0: acc <= zero-extended word; otherwise acc <= acc + zero-extended word (modulo 2^ACC_W).
  - If idx == BLOCK_LEN-1: output_1 <= final sum, output_1_valid <= 1, idx <= 0, go to EMIT. Otherwise idx++.
  - If FIFO empty: hold all state.
- FSM state EMIT:
  - No pops. FIFO keeps accepting pushes until full.
  - output_1 and output_1_valid are held stable until output_1_ready.
  - On output_1_valid & output_1_ready: output_1_valid <= 0, go to ACCUM. A pop may occur starting the next cycle.
  - output_1 retains its last value after the handshake.
- Latency: a word pushed at edge k is popped at edge k+1 earliest. With BLOCK_LEN = 1, output_1_valid rises at edge k+1.
- Throughput: one product per cycle in ACCUM. Each result costs at least one extra EMIT cycle.
- Overflow: silent wrap modulo 2^ACC_W; no flag.
- Reset mid-block: the partial sum and any buffered words are discarded; the next group starts fresh from idx 0.
- Flow invariants: no data loss or duplication under any valid/ready pattern. output_1 never changes while output_1_valid = 1 and output_1_ready = 0.

Decomposition:
- Shared package kpn_pkg:
  - default widths DATA_W and ACC_W;
  - FSM state typedef {ACCUM, EMIT};
  - a clog2 helper for pointer and index widths.
- One sub-module, kpn_fifo:
  - parameters WIDTH and DEPTH;
  - ports push, pop, din, dout, full, empty;
  - same clk and reset.
- The accumulator FSM and datapath live in the top module.

Test Plan:
1. BLOCK_LEN=3. Push 400, 25, 90 on consecutive cycles (the products of 20×20, 5×5, 10×9), with output_1_ready held at 1 → exactly one result, output_1 = 515, output_1_valid high for 1 cycle.
2. BLOCK_LEN=1, FIFO empty. Push 7 at edge k → output_1_valid = 1 and output_1 = 7 after edge k+1.
3. Backpressure, BLOCK_LEN=2:
   - Push 1, 2; hold output_1_ready = 0 for 10 cycles while continuously pushing 3, 4, 5, 6, 7.
   - Required: output_1 = 3 held stable; entry_1_ready drops to 0 after 3, 4, 5, 6 are buffered; 7 is not accepted.
   - Release ready → next results 7, 11, and 7 is then accepted.
4. Width and wrap:
   - ACC_W=40, BLOCK_LEN=3, three pushes of 0xFFFFFFFF → output_1 = 0x2FFFFFFFD.
   - ACC_W=32, BLOCK_LEN=2, pushes 0xFFFFFFFF, 2 → output_1 = 1.
5. Reset mid-operation, BLOCK_LEN=4:
   - Push 10, 20 with two more words buffered, then pulse reset asynchronously between edges.
   - Required: output_1 = 0, output_1_valid = 0 and FIFO empty immediately.
   - Then push 1, 2, 3, 4 → output_1 = 10.
6. Random stall soak: random entry_1_valid and output_1_ready for 2000 cycles, compared against a reference model → every group sum matches, in order, with no loss or duplicates.
